// File: rtl/read_capture_fifo_pkg.sv
// Shared defaults and the entry record for the read-capture FIFO slice.
`timescale 1ns/1ps
package read_capture_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DEPTH  = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/read_capture_fifo_if.sv
// Capture-in / show-ahead-out handshake bundle for the read-capture FIFO.
// The master side is the upstream capture stage plus the consumer; the slave
// side is the FIFO itself.
`timescale 1ns/1ps
interface read_capture_fifo_if #(
  parameter int DATA_W = read_capture_fifo_pkg::DEF_DATA_W,
  parameter int ADDR_W = read_capture_fifo_pkg::DEF_ADDR_W
);

  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_addr, in_valid, out_ready,
    input  out_data, out_addr, out_valid
  );

  modport slave (
    input  in_data, in_addr, in_valid, out_ready,
    output out_data, out_addr, out_valid
  );

endinterface

// File: rtl/read_capture_fifo_mem.sv
// Entry storage for the read-capture FIFO: one write port, one asynchronous
// read port, contents deliberately left unreset.
`timescale 1ns/1ps
module capture_fifo_mem #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry when the control logic accepts a capture.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/read_capture_fifo.sv
// Read-capture FIFO: queues {addr, data} captures from an upstream stage that
// cannot be stalled. Captures arriving while full and not draining are dropped
// and recorded in a sticky overflow flag plus a saturating drop counter.
`timescale 1ns/1ps
module read_capture_fifo
  import read_capture_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  read_capture_fifo_if.slave     bus,
  input  logic                   clear_overflow,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] rd_entry;
  logic               push;
  logic               pop;
  logic               drop;

  assign full          = (count == CNT_FULL);
  assign empty         = (count == '0);
  assign bus.out_valid = ~empty;

  assign pop  = bus.out_valid & bus.out_ready;
  assign push = bus.in_valid & (~full | pop);
  assign drop = bus.in_valid & full & ~pop;

  assign bus.out_addr = ARESETn ? rd_entry[ENTRY_W-1 -: ADDR_W] : '0;
  assign bus.out_data = ARESETn ? rd_entry[DATA_W-1:0] : '0;

  capture_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .ACLK    (ACLK),
    .wr_en   (push & ARESETn),
    .wr_addr (wr_ptr),
    .wr_data ({bus.in_addr, bus.in_data}),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Advance pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Track dropped captures; a drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clear_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: doc/read_capture_fifo.md
READ_CAPTURE_FIFO -- requirements
Module: read_capture_fifo

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning): DATA_W, 32, captured read-data width.
REQ-002 ADDR_W, 2, captured address width.
REQ-003 DEPTH, 4, entry count; a power of two, at least 2.
REQ-004 Ports (name, direction, width, meaning): ACLK, in, 1, single clock; all logic on the rising edge.
REQ-005 ARESETn, in, 1, reset; synchronous, active-low.
REQ-006 in_data, in, DATA_W, read data from the upstream read-capture stage.
REQ-007 in_addr, in, ADDR_W, read address from the upstream read-capture stage.
REQ-008 in_valid, in, 1, single-cycle qualifier from upstream; there is no backpressure path to upstream.
REQ-009 out_data, out, DATA_W, head-entry data.
REQ-010 out_addr, out, ADDR_W, head-entry address.
REQ-011 out_valid, out, 1, head entry present.
REQ-012 out_ready, in, 1, consumer accepts the head entry.
REQ-013 count, out, log2(DEPTH)+1, number of occupied entries.
REQ-014 full, out, 1, count equals DEPTH.
REQ-015 empty, out, 1, count equals 0.
REQ-016 overflow, out, 1, sticky flag: a capture was dropped.
REQ-017 drop_cnt, out, 8, saturating count of dropped captures.
REQ-018 clear_overflow, in, 1, clears overflow and drop_cnt.

Function
REQ-019 pop SHALL equal out_valid AND out_ready; push SHALL equal in_valid AND (NOT full OR pop).
REQ-020 On push, {in_addr, in_data} SHALL be written at wr_ptr, and wr_ptr SHALL advance by 1 modulo DEPTH.
REQ-021 On pop, rd_ptr SHALL advance by 1 modulo DEPTH.
REQ-022 Output is show-ahead: out_data and out_addr SHALL be read combinationally from the entry at rd_ptr, and out_valid SHALL equal NOT empty.
REQ-023 Latency: an entry pushed at edge N SHALL present out_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-024 Entries SHALL leave in arrival order; address and data of one entry SHALL never be split.
REQ-025 count update: push only, +1; pop only, -1; both or neither, unchanged.
REQ-026 full and empty SHALL be derived from count, never from pointer comparison alone.
REQ-027 Empty with in_valid=1: the entry is pushed; there is no same-cycle bypass to the output.
REQ-028 Full with in_valid=1 and pop=1: the entry is pushed, and count stays at DEPTH.
REQ-029 Full with in_valid=1 and pop=0: the entry is dropped, overflow SHALL be set to 1, and drop_cnt SHALL increment, saturating at 255.
REQ-030 If a drop event and clear_overflow=1 occur in the same cycle, the drop SHALL win: overflow=1 and drop_cnt=1.
REQ-031 clear_overflow=1 with no drop event SHALL clear overflow to 0 and drop_cnt to 0.
REQ-032 out_valid=0 with out_ready=1 SHALL have no effect.
REQ-033 out_data and out_addr SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-034 When ARESETn=0 at a rising edge, the following SHALL be cleared: wr_ptr=0, rd_ptr=0, count=0, overflow=0, drop_cnt=0.
REQ-035 Resulting reset outputs: out_valid=0, empty=1, full=0.
REQ-036 Storage contents need not be reset.
REQ-037 While ARESETn=0, out_data and out_addr SHALL drive 0.
REQ-038 Reset asserted mid-operation SHALL discard all entries; in_valid during reset SHALL be ignored and SHALL not count as a drop.

Structure
REQ-039 A shared package SHALL hold DATA_W, ADDR_W, DEPTH defaults and the entry record type {addr, data}.
REQ-040 Storage SHALL be a single sub-module, capture_fifo_mem: DEPTH x (ADDR_W+DATA_W), one write port and one asynchronous read port.
REQ-041 Pointer, count and flag logic SHALL reside in read_capture_fifo.

Verification
REQ-042 Reset then push (addr=1, data=0xDEADBEEF) with out_ready=0 -> next cycle out_valid=1, out_addr=1, out_data=0xDEADBEEF, count=1.
REQ-043 Push 4 entries 0x10..0x13 (addr 0..3), then out_ready=1 for 4 cycles -> pops in order 0x10,0x11,0x12,0x13; then empty=1, and full=1 was seen after the 4th push.
REQ-044 Full, 5th in_valid with out_ready=0 -> entry dropped, overflow=1, drop_cnt=1, head still 0x10; then clear_overflow -> overflow=0, drop_cnt=0.
REQ-045 Full, in_valid=1 (data 0x55) with out_ready=1 in the same cycle -> head 0x10 popped, 0x55 accepted as the tail entry, count stays 4.
REQ-046 300 drops while full -> drop_cnt saturates at 255; a drop and clear_overflow in the same cycle -> overflow=1, drop_cnt=1.
REQ-047 Two entries queued, ARESETn=0 for one cycle with in_valid=1 -> count=0, out_valid=0, overflow=0; after reset, 6 pushes and pops across the pointer wrap show no reordering.
